// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver (start, 8 data LSB first, odd parity, stop)
//   clock           : system clock
//   resetn          : asynchronous active-low reset
//   PS2_CLK/PS2_DAT : raw asynchronous PS/2 lines
//   ps2_key_data    : last valid byte, held between frames
//   ps2_key_pressed : one-cycle strobe, ps2_key_data updates in the same cycle
//   parity_error    : one-cycle strobe, frame discarded on bad parity
//   frame_error     : one-cycle strobe, bad stop bit or mid-frame timeout
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] ps2_key_data,
    output logic       ps2_key_pressed,
    output logic       parity_error,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t        state, state_n;
    logic [1:0]    clk_s, dat_s;
    logic          clk_f, clk_f_q;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] tcnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic          fe, dat, tmo, key_ok, perr, ferr;
    assign fe  = clk_f_q & ~clk_f;
    assign dat = dat_s[1];
    // Abort when the next count would reach the limit; an edge in that cycle wins.
    assign tmo = (state != IDLE) && !fe && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_f    <= 1'b1;
            clk_f_q  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s   <= {clk_s[0], PS2_CLK};
            dat_s   <= {dat_s[0], PS2_DAT};
            clk_f_q <= clk_f;
            // The FILTER_LEN-th consecutive differing sample flips the level.
            if (clk_s[1] == clk_f)
                filt_cnt <= '0;
            else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_f    <= clk_s[1];
                filt_cnt <= '0;
            end else
                filt_cnt <= filt_cnt + 1'b1;
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (tmo)
            state_n = IDLE;
        else if (fe)
            case (state)
                IDLE:    state_n = dat ? IDLE : DATA;
                DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_n = STOP;
                STOP:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
    end
    always_comb begin
        key_ok = fe && state == STOP && dat && (^shreg ^ par);
        perr   = fe && state == STOP && dat && !(^shreg ^ par);
        ferr   = (fe && state == STOP && !dat) || tmo;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tcnt            <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            par             <= 1'b0;
            ps2_key_data    <= '0;
            ps2_key_pressed <= 1'b0;
            parity_error    <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            tcnt            <= (fe || state == IDLE || tmo) ? '0 : tcnt + 1'b1;
            ps2_key_pressed <= key_ok;
            parity_error    <= perr;
            frame_error     <= ferr;
            if (key_ok)
                ps2_key_data <= shreg;
            if (fe && state == IDLE)
                bit_cnt <= '0;
            if (fe && state == DATA) begin
                shreg[bit_cnt] <= dat;
                bit_cnt        <= bit_cnt + 3'd1;
            end
            if (fe && state == PARITY)
                par <= dat;
        end
    end
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: directed checks of the PS/2 frame receiver
module tb_ps2_rx_frame;
    localparam int FL = 8;
    localparam int TO = 200;
    localparam int HP = 40;
    localparam int LAT = 2 + FL + 1;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed, parity_error, frame_error;
    int n_cmp = 0, n_err = 0;
    int cyc = 0, last_edge = 0, press_cyc = 0, ferr_cyc = 0;
    int n_press = 0, n_perr = 0, n_ferr = 0, n_chg = 0, n_bad_chg = 0, n_overlap = 0;
    logic [7:0] prev_data = 8'h00;
    int p0, e0, f0, c0, w;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .resetn(resetn), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
        .parity_error(parity_error), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        #1;
        if (resetn) begin
            if (ps2_key_pressed) begin n_press++; press_cyc = cyc; end
            if (parity_error) n_perr++;
            if (frame_error) begin n_ferr++; ferr_cyc = cyc; end
            if (ps2_key_data !== prev_data) begin
                n_chg++;
                if (ps2_key_pressed !== 1'b1) n_bad_chg++;
            end
            if (int'(ps2_key_pressed) + int'(parity_error) + int'(frame_error) > 1) n_overlap++;
        end
        prev_data = ps2_key_data;
    end

    initial begin
        #5ms;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v, input bit g);
        ps2_dat = v;
        repeat (HP / 2) @(negedge clock);
        ps2_clk = 1'b0;
        last_edge = cyc;
        repeat (HP) @(negedge clock);
        ps2_clk = 1'b1;
        if (g) begin
            repeat (8) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clock);
            ps2_clk = 1'b1;
        end
        repeat (HP / 2) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic stp,
                              input int nbits, input int glitch_at);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i], glitch_at == i);
        if (nbits == 8) begin
            send_bit(p, 1'b0);
            send_bit(stp, 1'b0);
        end
        ps2_dat = 1'b1;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_data", ps2_key_data, 8'h00);
        check("reset_pressed", ps2_key_pressed, 1'b0);
        check("reset_perr", parity_error, 1'b0);
        check("reset_ferr", frame_error, 1'b0);
        resetn = 1'b1;
        repeat (20) @(negedge clock);

        p0 = n_press; e0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b1, 8, -1);
        check("t1_press_cnt", n_press - p0, 1);
        check("t1_data", ps2_key_data, 8'h1C);
        check("t1_perr_cnt", n_perr - e0, 0);
        check("t1_ferr_cnt", n_ferr - f0, 0);
        check("t1_latency", press_cyc - last_edge, LAT);

        p0 = n_press; c0 = n_chg;
        send_frame(8'hF0, 1'b1, 1'b1, 8, -1);
        check("t2_data_f0", ps2_key_data, 8'hF0);
        send_frame(8'h75, 1'b0, 1'b1, 8, -1);
        check("t2_data_75", ps2_key_data, 8'h75);
        check("t2_press_cnt", n_press - p0, 2);
        check("t2_change_cnt", n_chg - c0, 2);
        check("t2_bad_change", n_bad_chg, 0);

        send_frame(8'h1C, 1'b0, 1'b1, 8, -1);
        p0 = n_press; e0 = n_perr; f0 = n_ferr;
        send_frame(8'h29, 1'b1, 1'b1, 8, -1);
        check("t3_perr_cnt", n_perr - e0, 1);
        check("t3_press_cnt", n_press - p0, 0);
        check("t3_ferr_cnt", n_ferr - f0, 0);
        check("t3_data", ps2_key_data, 8'h1C);

        p0 = n_press; e0 = n_perr; f0 = n_ferr;
        send_frame(8'h16, 1'b0, 1'b0, 8, -1);
        check("t4_ferr_cnt", n_ferr - f0, 1);
        check("t4_press_cnt", n_press - p0, 0);
        check("t4_perr_cnt", n_perr - e0, 0);
        check("t4_data", ps2_key_data, 8'h1C);

        p0 = n_press; f0 = n_ferr;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h16 >> i) & 8'h01) != 0, 1'b0);
        ps2_dat = 1'b1;
        w = 0;
        while (n_ferr == f0 && w < TO + 100) begin
            @(negedge clock);
            w++;
        end
        check("t5_ferr_cnt", n_ferr - f0, 1);
        check("t5_timeout_time", ferr_cyc - last_edge, TO + LAT);
        check("t5_press_cnt", n_press - p0, 0);
        repeat (20) @(negedge clock);
        send_frame(8'h16, 1'b0, 1'b1, 8, -1);
        check("t5_data", ps2_key_data, 8'h16);
        check("t5_press_after", n_press - p0, 1);

        p0 = n_press; e0 = n_perr; f0 = n_ferr;
        ps2_dat = 1'b0;
        repeat (10) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clock);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clock);
        send_frame(8'h29, 1'b0, 1'b1, 8, 3);
        check("t6_glitch_data", ps2_key_data, 8'h29);
        check("t6_glitch_press", n_press - p0, 1);
        check("t6_glitch_errs", (n_perr - e0) + (n_ferr - f0), 0);

        p0 = n_press; e0 = n_perr; f0 = n_ferr;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_data", ps2_key_data, 8'h00);
        check("t6_async_pressed", ps2_key_pressed, 1'b0);
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        check("t6_reset_strobes", (n_press - p0) + (n_perr - e0) + (n_ferr - f0), 0);
        send_frame(8'h75, 1'b0, 1'b1, 8, -1);
        check("t6_data_75", ps2_key_data, 8'h75);
        check("t6_press_cnt", n_press - p0, 1);
        check("t6_err_cnt", (n_perr - e0) + (n_ferr - f0), 0);

        check("overlap", n_overlap, 0);
        check("bad_change", n_bad_chg, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
